dac_sequencer: RTL

DAC_SEQUENCER -- requirements
Module: dac_sequencer

---
 rtl/dac_sequencer.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/dac_sequencer.sv
// -----------------------------------------------------------------------------
// dac_sequencer
//
// Purpose:
//   Avalon-MM programmable sample sequencer for a parallel 8-bit DAC. Software
//   fills a DEPTH-entry sample buffer, sets a sample divider and a sequence
//   length, then starts playback. Samples are presented on dac_data with a
//   one-clock dac_wr strobe every DIV+1 clocks. The sequence is played once
//   (raising done/irq at the end) or looped until software stops it.
//
// Parameters:
//   DEPTH  number of sample-buffer entries (power of 2, 2..256)
//   AW     buffer address width, log2(DEPTH)
//
// Ports:
//   clk         the only clock, rising edge
//   reset_n     synchronous active-low reset
//   address     register select (0 CTRL, 1 DIV, 2 LEN, 3 STATUS, 4 DATA,
//               5 WPTR, 6 RPTR, 7 reserved)
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data
//   readdata    registered read data, 1-cycle latency
//   dac_data    registered DAC sample
//   dac_wr      one-clock strobe, high while dac_data holds a new sample
//   irq         level interrupt = STATUS.done & CTRL.irq_en
// -----------------------------------------------------------------------------
module dac_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [7:0]  dac_data,
    output logic        dac_wr,
    output logic        irq
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [AW:0] DEPTH_LEN = (AW+1)'(DEPTH);

    // Register file and sequencer state
    state_t          state_reg;
    logic            run_reg;
    logic            loop_reg;
    logic            irq_en_reg;
    logic [15:0]     div_reg;
    logic [AW:0]     len_reg;
    logic            done_reg;
    logic [AW-1:0]   wptr_reg;
    logic [AW-1:0]   rptr_reg;
    logic [15:0]     div_cnt_reg;
    logic [AW:0]     count_reg;
    logic [31:0]     readdata_reg;
    logic [7:0]      dac_data_reg;
    logic            dac_wr_reg;

    // Sample buffer; read through the dac_data register
    logic [7:0]      sample_mem [DEPTH];

    // Bus decode
    logic            wr;
    logic            wr_ctrl;
    logic            wr_div;
    logic            wr_len;
    logic            wr_status;
    logic            wr_data;
    logic            wr_wptr;

    logic            len_ok;
    logic [AW:0]     count_inc;
    logic            last_sample;
    logic [31:0]     readdata_next;

    // Upper write-data bits are never stored anywhere
    logic            unused_wdata;
    assign unused_wdata = &{1'b0, writedata[31:16]};

    assign wr        = chipselect & ~write_n;
    assign wr_ctrl   = wr && (address == 3'd0);
    assign wr_div    = wr && (address == 3'd1);
    assign wr_len    = wr && (address == 3'd2);
    assign wr_status = wr && (address == 3'd3);
    assign wr_data   = wr && (address == 3'd4);
    assign wr_wptr   = wr && (address == 3'd5);

    assign len_ok      = (len_reg != '0) && (len_reg <= DEPTH_LEN);
    assign count_inc   = count_reg + 1'b1;
    // >= rather than == so that shrinking LEN mid-run cannot strand the count
    assign last_sample = (count_inc >= len_reg);

    always_comb begin
        readdata_next = 32'd0;
        case (address)
            3'd0:    readdata_next = {29'd0, irq_en_reg, loop_reg, run_reg};
            3'd1:    readdata_next = {16'd0, div_reg};
            3'd2:    readdata_next = 32'(len_reg);
            3'd3:    readdata_next = {30'd0, done_reg, (state_reg == RUN)};
            3'd5:    readdata_next = 32'(wptr_reg);
            3'd6:    readdata_next = 32'(rptr_reg);
            default: readdata_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_data) begin
            sample_mem[wptr_reg] <= writedata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            run_reg      <= 1'b0;
            loop_reg     <= 1'b0;
            irq_en_reg   <= 1'b0;
            div_reg      <= '0;
            len_reg      <= '0;
            done_reg     <= 1'b0;
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            div_cnt_reg  <= '0;
            count_reg    <= '0;
            readdata_reg <= '0;
            dac_data_reg <= '0;
            dac_wr_reg   <= 1'b0;
        end else begin
            readdata_reg <= readdata_next;
            dac_wr_reg   <= 1'b0;

            if (wr_div) begin
                div_reg <= writedata[15:0];
            end
            if (wr_len) begin
                len_reg <= writedata[AW:0];
            end

            if (wr_wptr) begin
                wptr_reg <= writedata[AW-1:0];
            end else if (wr_data) begin
                wptr_reg <= wptr_reg + 1'b1;
            end

            // Any STATUS write clears done; a done-set below overrides it
            if (wr_status) begin
                done_reg <= 1'b0;
            end

            case (state_reg)
                IDLE: begin
                    if (wr_ctrl) begin
                        loop_reg   <= writedata[1];
                        irq_en_reg <= writedata[2];
                        if (writedata[0] && len_ok) begin
                            run_reg     <= 1'b1;
                            state_reg   <= RUN;
                            rptr_reg    <= '0;
                            count_reg   <= '0;
                            div_cnt_reg <= '0;
                        end else begin
                            // Invalid LEN refuses the start
                            run_reg <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    if (wr_ctrl && !writedata[0]) begin
                        // Software stop: no sample at this edge, dac_data holds
                        run_reg    <= 1'b0;
                        loop_reg   <= writedata[1];
                        irq_en_reg <= writedata[2];
                        state_reg  <= IDLE;
                    end else begin
                        // A run=1 write while running only touches loop/irq_en
                        if (wr_ctrl) begin
                            loop_reg   <= writedata[1];
                            irq_en_reg <= writedata[2];
                        end
                        if (div_cnt_reg == '0) begin
                            dac_data_reg <= sample_mem[rptr_reg];
                            dac_wr_reg   <= 1'b1;
                            div_cnt_reg  <= div_reg;
                            if (last_sample && loop_reg) begin
                                rptr_reg  <= '0;
                                count_reg <= '0;
                            end else begin
                                rptr_reg  <= rptr_reg + 1'b1;
                                count_reg <= count_inc;
                                if (last_sample) begin
                                    state_reg <= IDLE;
                                    run_reg   <= 1'b0;
                                    done_reg  <= 1'b1;
                                end
                            end
                        end else begin
                            div_cnt_reg <= div_cnt_reg - 16'd1;
                        end
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    assign readdata = readdata_reg;
    assign dac_data = dac_data_reg;
    assign dac_wr   = dac_wr_reg;
    assign irq      = done_reg & irq_en_reg;

endmodule
